// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the memory-stage responder.
package data_mem_responder_pkg;

  // Responder state encodings, kept alongside the control FSM's own states.
  localparam int MRSP_STATE_LEN = 2;

  typedef enum logic [MRSP_STATE_LEN-1:0] {
    MRSP_IDLE = 2'd0,
    MRSP_WAIT = 2'd1,
    MRSP_RESP = 2'd2
  } mrsp_state_t;

  // Wait-state counter width: covers WAIT_CYCLES in 0..15.
  localparam int CNT_W = 4;

  // A word access must have both low byte-address bits clear.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
module data_mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Store port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the MEM-stage handshake: accepts one request per MEM-state
// entry, waits a fixed number of cycles, then performs the access and pulses
// mem_ready for one cycle.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_err
);

  mrsp_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  armed;
  logic                  accept;
  logic                  go_resp;

  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [ADDR_WIDTH-1:0] in_idx;
  logic                  misalign_in;

  logic                  txn_we;
  logic [ADDR_WIDTH-1:0] txn_idx;
  logic [DATA_WIDTH-1:0] txn_wdata;
  logic                  txn_err;

  logic                  arr_we;
  logic                  ld_en;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Address bits above the word index are deliberately ignored (index wraps).
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:ADDR_WIDTH+2];

  assign in_idx      = mem_addr[ADDR_WIDTH+1:2];
  assign misalign_in = addr_misaligned(mem_addr);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MRSP_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, accept decode and status outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mem_ready = 1'b0;
    mem_busy  = 1'b0;
    case (state)
      MRSP_IDLE: begin
        if (mem_req && armed) begin
          accept = 1'b1;
          if (misalign_in || (WAIT_CYCLES == 0)) state_nxt = MRSP_RESP;
          else                                   state_nxt = MRSP_WAIT;
        end
      end
      MRSP_WAIT: begin
        mem_busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = MRSP_RESP;
      end
      MRSP_RESP: begin
        mem_busy  = 1'b1;
        mem_ready = 1'b1;
        state_nxt = MRSP_IDLE;
      end
      default: state_nxt = MRSP_IDLE;
    endcase
  end

  // Transaction fields: live inputs on the accept edge (zero-wait or
  // misaligned goes straight to RESP), latched copies afterwards.
  always_comb begin
    txn_we    = lat_we;
    txn_idx   = lat_idx;
    txn_wdata = lat_wdata;
    txn_err   = 1'b0;
    if (state == MRSP_IDLE) begin
      txn_we    = mem_we;
      txn_idx   = in_idx;
      txn_wdata = mem_wdata;
      txn_err   = misalign_in;
    end
  end

  assign go_resp = (state != MRSP_RESP) && (state_nxt == MRSP_RESP);
  assign arr_we  = go_resp && txn_we && !txn_err;
  assign ld_en   = go_resp && !txn_we && !txn_err;

  // Control state: wait counter, re-arm flag, error flag and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      armed     <= 1'b1;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (accept)                  cnt <= CNT_W'(WAIT_CYCLES);
      else if (state == MRSP_WAIT) cnt <= cnt - CNT_W'(1);

      if (!mem_req)    armed <= 1'b1;
      else if (accept) armed <= 1'b0;

      if (accept) mem_err   <= misalign_in;
      if (ld_en)  mem_rdata <= arr_rdata;
    end
  end

  // Request capture; later input changes have no effect on the transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= mem_we;
      lat_idx   <= in_idx;
      lat_wdata <= mem_wdata;
    end
  end

  data_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(txn_idx),
    .wdata(txn_wdata),
    .raddr(txn_idx),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_data_mem_responder;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int WAIT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          mem_busy;
  logic          mem_err;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [DW-1:0] ref_mem   [0:(2**AW)-1];
  bit            ref_valid [0:(2**AW)-1];
  int            written[$];
  logic [DW-1:0] exp_rdata;

  data_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_busy (mem_busy),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic mid_cycle_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_ready"}, 64'(mem_ready), 64'd0);
    check({tag, "_busy"},  64'(mem_busy),  64'd0);
    check({tag, "_err"},   64'(mem_err),   64'd0);
    check({tag, "_rdata"}, 64'(mem_rdata), 64'd0);
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rdata = '0;
  endtask

  // Issue one transaction (called at edge+1 with mem_req already low for an
  // edge), check latency, busy, result and single-pulse behaviour.
  task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [DW-1:0] wdata, input int exp_lat,
                         input logic [DW-1:0] exp_rd, input logic exp_err, input int hold);
    int  n;
    int  extra;
    bit  busy_bad;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_req   = 1'b1;
    @(posedge clk); #1;
    n = 1;
    busy_bad = 0;
    while (mem_ready !== 1'b1 && n < 40) begin
      if (mem_busy !== 1'b1) busy_bad = 1;
      mem_we    = ~we;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"},     64'(mem_ready), 64'd1);
    check({tag, "_latency"},   64'(n),         64'(exp_lat));
    check({tag, "_busy_wait"}, 64'(busy_bad),  64'd0);
    check({tag, "_busy_resp"}, 64'(mem_busy),  64'd1);
    check({tag, "_err"},       64'(mem_err),   64'(exp_err));
    check({tag, "_rdata"},     64'(mem_rdata), 64'(exp_rd));
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) extra++;
    end
    if (hold > 0) check({tag, "_held_pulses"}, 64'(extra), 64'd0);
    mem_req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 64'(mem_ready), 64'd0);
    check({tag, "_idle_busy"}, 64'(mem_busy),  64'd0);
  endtask

  // Reference model: word index = byte address / 4 modulo depth; misaligned
  // accesses touch nothing and answer after one cycle.
  task automatic model_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [DW-1:0] wdata, input int hold);
    int idx;
    int lat;
    bit mis;
    idx = int'((addr / 4) % (2**AW));
    mis = (addr % 4) != 0;
    lat = mis ? 1 : WAIT + 1;
    if (!mis) begin
      if (we) begin
        ref_mem[idx] = wdata;
        if (!ref_valid[idx]) written.push_back(idx);
        ref_valid[idx] = 1;
      end else begin
        exp_rdata = ref_mem[idx];
      end
    end
    run_txn(tag, we, addr, wdata, lat, exp_rdata, mis, hold);
  endtask

  initial begin
    int pulses;
    int r;
    int idx;
    logic [31:0] a;

    for (int i = 0; i < 2**AW; i++) ref_valid[i] = 0;
    exp_rdata = '0;
    rst_n     = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Power-on reset, asserted between edges.
    mid_cycle_reset("por");

    // Store then load.
    model_txn("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 0);
    model_txn("lw_10", 1'b0, 32'h10, 32'h0, 0);

    // Held request: one pulse per MEM entry.
    model_txn("held_lw", 1'b0, 32'h10, 32'h0, 10);
    model_txn("rearm_lw", 1'b0, 32'h10, 32'h0, 0);

    // Misaligned store: no write, error flagged.
    model_txn("sw_13", 1'b1, 32'h13, 32'h11111111, 0);
    model_txn("lw_10b", 1'b0, 32'h10, 32'h0, 0);

    // Misaligned flag and load data clear on reset; array contents survive.
    model_txn("lw_12", 1'b0, 32'h12, 32'h0, 0);
    mid_cycle_reset("rst_err");
    model_txn("lw_10c", 1'b0, 32'h10, 32'h0, 0);

    // Index wrap above ADDR_WIDTH+1.
    model_txn("sw_400", 1'b1, 32'h400, 32'h1234, 0);
    model_txn("lw_0", 1'b0, 32'h0, 32'h0, 0);

    // Abort: reset during WAIT suppresses write and response.
    model_txn("sw_20_pre", 1'b1, 32'h20, 32'hCAFE0020, 0);
    mem_we    = 1'b1;
    mem_addr  = 32'h20;
    mem_wdata = 32'h55;
    mem_req   = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_before", 64'(mem_busy), 64'd1);
    mid_cycle_reset("abort");
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) pulses++;
    end
    check("abort_no_ready", 64'(pulses), 64'd0);
    model_txn("lw_20_post", 1'b0, 32'h20, 32'h0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        model_txn("rnd_mis", 1'($urandom_range(0, 1)), a, $urandom, 0);
      end else if (r < 4 || written.size() == 0) begin
        model_txn("rnd_sw", 1'b1, $urandom & 32'hFFFF_FFFC, $urandom, 0);
      end else begin
        idx = written[$urandom_range(0, written.size() - 1)];
        a = ($urandom & 32'hFFFF_FC00) | 32'(idx * 4);
        model_txn("rnd_lw", 1'b0, a, $urandom, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
